// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//
// Shares the single push port of the parity FIFO between NUM_REQ independent
// producers. A round-robin scan picks one eligible producer per cycle and
// loads its payload into a one-entry output register. That register drives
// the FIFO push interface.
//
// Handshake (every producer port and the FIFO port): valid is held high with
// stable data until grant. A transfer happens on a rising clk edge where
// valid and grant are both high. Grants here are combinational and never go
// to a deasserted or masked valid.
//
// Ports:
//   clk          - single clock, rising edge
//   reset_n      - synchronous active-low reset
//   req_valid_i  - per-requester push valid
//   req_data_i   - per-requester payload, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_mask_i   - per-requester eligibility enable (1 = may be granted)
//   req_grant_o  - per-requester grant, one-hot or zero
//   push_valid_o - to FIFO push_valid_i
//   push_data_o  - to FIFO push_data_i
//   push_grant_i - from FIFO push_grant_o
//   push_src_o   - index of the requester whose data sits in the output register
//   busy_o       - output register occupied (same as push_valid_o)
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_mask_i,
  output logic [NUM_REQ-1:0]            req_grant_o,
  output logic                          push_valid_o,
  output logic [DATA_WIDTH-1:0]         push_data_o,
  input  logic                          push_grant_i,
  output logic [ID_WIDTH-1:0]           push_src_o,
  output logic                          busy_o
);

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   out_src;
  logic [ID_WIDTH-1:0]   last_winner;

  logic [NUM_REQ-1:0]    elig;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  can_load;
  logic                  found;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic                  load;

  assign elig = req_valid_i & req_mask_i;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Draining the register and refilling it in the same cycle gives one
  // transfer per cycle when the FIFO keeps granting.
  assign can_load = !out_valid || push_grant_i;

  // Scan starts just after last_winner and wraps at NUM_REQ-1 back to 0,
  // so the previous winner has lowest priority.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = last_winner;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (scan_idx == LAST_IDX) begin
        scan_idx = '0;
      end else begin
        scan_idx = scan_idx + ID_WIDTH'(1);
      end
      if (!found && elig[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign load = reset_n && can_load && found;

  always_comb begin
    req_grant_o = '0;
    if (load) begin
      req_grant_o[winner] = 1'b1;
    end
  end

  // Priority only rotates on a requester grant, so FIFO backpressure cannot
  // shuffle the order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= '0;
      last_winner <= LAST_IDX;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= data_arr[winner];
      out_src     <= winner;
      last_winner <= winner;
    end else if (out_valid && push_grant_i) begin
      // Drained with no refill; data and source are left as they were.
      out_valid <= 1'b0;
    end
  end

  assign push_valid_o = out_valid;
  assign push_data_o  = out_data;
  assign push_src_o   = out_src;
  assign busy_o       = out_valid;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int IW      = 2;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*DW-1:0] req_data_i;
  logic [NUM_REQ-1:0]    req_mask_i;
  logic [NUM_REQ-1:0]    req_grant_o;
  logic                  push_valid_o;
  logic [DW-1:0]         push_data_o;
  logic                  push_grant_i;
  logic [IW-1:0]         push_src_o;
  logic                  busy_o;

  logic [IW+DW-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  fifo_push_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_mask_i   (req_mask_i),
    .req_grant_o  (req_grant_o),
    .push_valid_o (push_valid_o),
    .push_data_o  (push_data_o),
    .push_grant_i (push_grant_i),
    .push_src_o   (push_src_o),
    .busy_o       (busy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    req_data_i[k*DW +: DW] = v;
  endtask

  task automatic expect_push(input logic [IW-1:0] src, input logic [DW-1:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Comb outputs are settled a few ns after the inputs change.
  task automatic check_grant(input string name, input logic [NUM_REQ-1:0] exp);
    #2;
    check(name, 32'(req_grant_o), 32'(exp));
  endtask

  // ---------------- scoreboard monitor ----------------
  // A FIFO push happens at the next rising edge when valid and grant are high.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && push_valid_o === 1'b1 && push_grant_i === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL push_unexpected: got src %0d data 0x%0h, expected no push",
                 push_src_o, push_data_o);
      end else begin
        logic [IW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({push_src_o, push_data_o} !== e) begin
          tests_failed++;
          $display("FAIL push_data: got src %0d data 0x%0h, expected src %0d data 0x%0h",
                   push_src_o, push_data_o, e[IW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    req_valid_i  = 4'b1111;
    req_mask_i   = 4'b1111;
    push_grant_i = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) set_data(k, 8'hA0 + 8'(k));

    // Reset held for two cycles with everyone requesting.
    step();
    step();
    check_grant("reset_grant", 4'b0000);
    check("reset_push_valid", 32'(push_valid_o), 0);
    check("reset_push_src", 32'(push_src_o), 0);
    check("reset_busy", 32'(busy_o), 0);

    // Round robin with the FIFO always granting: 0,1,2,3,0.
    reset_n      = 1'b1;
    push_grant_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_grant($sformatf("rr_grant_%0d", i), 4'(1 << (i % 4)));
      expect_push(IW'(i % 4), 8'hA0 + 8'(i % 4));
      step();
    end
    req_valid_i = 4'b0000;
    #2;
    check("rr_tail_valid", 32'(push_valid_o), 1);
    step();
    check("rr_drained", 32'(push_valid_o), 0);

    // Backpressure: requester 2 loads 0x5C and waits three cycles.
    set_data(2, 8'h5C);
    req_valid_i  = 4'b0100;
    push_grant_i = 1'b0;
    check_grant("bp_load_grant", 4'b0100);
    expect_push(2'd2, 8'h5C);
    step();
    req_valid_i = 4'b0010;
    set_data(1, 8'h31);
    for (int i = 0; i < 3; i++) begin
      check_grant($sformatf("bp_hold_grant_%0d", i), 4'b0000);
      check($sformatf("bp_hold_valid_%0d", i), 32'(push_valid_o), 1);
      check($sformatf("bp_hold_data_%0d", i), 32'(push_data_o), 32'h5C);
      check($sformatf("bp_hold_src_%0d", i), 32'(push_src_o), 2);
      if (i < 2) step();
    end
    step();
    push_grant_i = 1'b1;
    check_grant("bp_release_grant", 4'b0010);
    expect_push(2'd1, 8'h31);
    step();
    req_valid_i = 4'b0000;
    #2;
    check("bp_reload_src", 32'(push_src_o), 1);
    check("bp_reload_valid", 32'(push_valid_o), 1);
    step();
    step();

    // Wrap: make 3 the last winner, then 0 and 3 compete.
    set_data(3, 8'hD3);
    req_valid_i = 4'b1000;
    check_grant("wrap_setup_grant", 4'b1000);
    expect_push(2'd3, 8'hD3);
    step();
    set_data(0, 8'hE0);
    set_data(3, 8'hD4);
    req_valid_i = 4'b1001;
    check_grant("wrap_first_grant", 4'b0001);
    expect_push(2'd0, 8'hE0);
    step();
    req_valid_i = 4'b1000;
    check_grant("wrap_second_grant", 4'b1000);
    expect_push(2'd3, 8'hD4);
    step();
    req_valid_i = 4'b0000;
    step();
    step();

    // Masking: requester 1 pending but masked.
    set_data(1, 8'h41);
    set_data(2, 8'h42);
    req_valid_i = 4'b0110;
    req_mask_i  = 4'b0100;
    check_grant("mask_grant_2", 4'b0100);
    expect_push(2'd2, 8'h42);
    step();
    req_valid_i = 4'b0010;
    check_grant("mask_blocked", 4'b0000);
    step();
    req_mask_i = 4'b0110;
    check_grant("mask_unblocked", 4'b0010);
    expect_push(2'd1, 8'h41);
    step();
    req_valid_i = 4'b0000;
    req_mask_i  = 4'b1111;
    step();
    step();

    // Mid-operation reset: 0x77 from requester 1 held, then discarded.
    set_data(1, 8'h77);
    req_valid_i  = 4'b0010;
    push_grant_i = 1'b0;
    check_grant("rst_load_grant", 4'b0010);
    step();
    req_valid_i = 4'b0000;
    #2;
    check("rst_held_data", 32'(push_data_o), 32'h77);
    step();
    reset_n     = 1'b0;
    req_valid_i = 4'b1111;
    check_grant("rst_active_grant", 4'b0000);
    step();
    reset_n      = 1'b1;
    push_grant_i = 1'b1;
    set_data(0, 8'h90);
    req_valid_i  = 4'b1011;
    check_grant("rst_restart_grant", 4'b0001);
    check("rst_cleared_valid", 32'(push_valid_o), 0);
    expect_push(2'd0, 8'h90);
    step();
    req_valid_i = 4'b0000;
    step();
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the single push port of the parity FIFO top between NUM_REQ independent producers.
- Uses a round-robin policy with a one-entry registered output stage.
- Sits directly upstream of the FIFO's push_valid_i/push_data_i/push_grant_o interface.
- Each producer port and the FIFO port use the same valid/grant handshake: valid is held with stable data until grant; transfer occurs on a clock edge where valid and grant are both high.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width; matches the FIFO DATA_WIDTH.
- ID_WIDTH, $clog2(NUM_REQ) (minimum 1), width of the source-id output.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req_valid_i  in  NUM_REQ  per-requester push valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_mask_i  in  NUM_REQ  1 = requester k eligible for arbitration; 0 = ignored.
- req_grant_o  out  NUM_REQ  per-requester grant, one-hot or zero.
- push_valid_o  out  1  to FIFO push_valid_i.
- push_data_o  out  DATA_WIDTH  to FIFO push_data_i.
- push_grant_i  in  1  from FIFO push_grant_o.
- push_src_o  out  ID_WIDTH  index of the requester whose data is in the output register.
- busy_o  out  1  output register occupied (equals push_valid_o).

Behaviour:
- State: output register (out_valid, out_data, out_src) and round-robin pointer last_winner (ID_WIDTH).
- Reset, synchronous while reset_n=0 at a rising edge:
  - out_valid=0, out_data=0, out_src=0, last_winner=NUM_REQ-1, so requester 0 has top priority.
  - req_grant_o is forced to 0 while reset_n=0.
- Reset asserted mid-transfer discards the held entry; that payload is not re-presented.
- Eligibility: elig[k] = req_valid_i[k] & req_mask_i[k].
- Load condition: can_load = !out_valid | push_grant_i. This is combinational and gives a full-throughput pass-through.
- Winner selection:
  - Winner is the first eligible index scanning last_winner+1, last_winner+2, ... modulo NUM_REQ.
  - The scan wraps; index NUM_REQ-1 is followed by 0.
- Grant generation:
  - req_grant_o[w] = can_load & elig[w] for the winner only; combinational; at most one bit set.
  - No eligible requester, or !can_load, gives req_grant_o = 0.
- Edge with a grant to winner w:
  - out_valid<=1, out_data<=req_data_i[w], out_src<=w, last_winner<=w.
- Edge with push_grant_i=1, out_valid=1 and no new winner: out_valid<=0. out_data and out_src hold their values.
- Edge with push_grant_i=1 and a new winner in the same cycle: the register is reloaded and out_valid stays 1. Sustained rate is one transfer per cycle.
- push_grant_i while out_valid=0 is ignored.
- Output stability: push_valid_o=out_valid. push_data_o and push_src_o are stable while push_valid_o=1 and push_grant_i=0.
- Latency: a requester granted at edge N has its data on push_valid_o/push_data_o from edge N to the edge where the FIFO grants.
- Pointer update: last_winner changes only on a requester grant. FIFO backpressure does not rotate priority.
- Masking: a requester masked while its valid is high is not granted; its valid stays pending. An entry already loaded into the output register is unaffected by later mask changes.
- Requirement on requesters: valid must not drop before grant. Dropping it early is a protocol violation; the block only requires that no grant is issued to a deasserted valid.
- Starvation bound: an eligible requester is granted within NUM_REQ grant events.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all req_valid_i=1111 -> req_grant_o=0000, push_valid_o=0, push_src_o=0. On release, first grant goes to requester 0.
- Round-robin, FIFO always granting: all 4 requesters valid; data 0xA0..0xA3; push_grant_i=1 -> grants 0,1,2,3,0 in consecutive cycles; push_data_o sequence A0,A1,A2,A3, one per cycle.
- Backpressure: requester 2 pushes 0x5C; push_grant_i=0 for 3 cycles -> push_valid_o=1, push_data_o=0x5C, push_src_o=2 stable; req_grant_o=0 while requester 1 is valid. The cycle push_grant_i=1 grants requester 1 in the same cycle.
- Wrap and pointer: last_winner=3; requesters 0 and 3 valid -> requester 0 wins first, then 3.
- Masking: req_valid_i=0110, req_mask_i=0100 -> only requester 2 is granted; requester 1 is granted once its mask bit is set.
- Mid-operation reset: entry 0x77 from requester 1 held under backpressure; assert reset_n=0 for 1 cycle -> push_valid_o=0 next cycle; 0x77 is never pushed; priority restarts at requester 0.
